seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), iteration-counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level request to start a multiply; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement (Booth radix-2), 0 = unsigned (shift-add); sampled with run.
REQ-007 Multiplicand  input  WIDTH  first operand; sampled with run.
REQ-008 Multiplier  input  WIDTH  second operand; sampled with run.
REQ-009 Product  output  2*WIDTH  registered result.
REQ-010 ready  output  1  high while a completed result is presented.
REQ-011 busy  output  1  high while iterating (CALC state).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE, run=1 at a rising edge: latch Multiplicand, Multiplier and is_signed, clear accumulator and counter, go to CALC.
REQ-014 IDLE, run=0: remain in IDLE; Product and ready unchanged.
REQ-015 CALC: one iteration per rising edge, exactly WIDTH iterations.
REQ-016 Unsigned iteration: if the multiplier LSB is 1, add the multiplicand to the high half with a carry bit, then shift {carry, high, low} right by 1.
REQ-017 Signed iteration: apply the Booth pair {LSB, q_-1}: 01 adds the multiplicand, 10 subtracts it, 00/11 leave it; then arithmetic-shift {high, low, q_-1} right by 1.
REQ-018 On the edge completing iteration WIDTH: load Product with the 2*WIDTH result, set ready=1, go to DONE.
REQ-019 Latency: ready SHALL rise exactly WIDTH rising edges after the edge that accepted run.
REQ-020 Operand, is_signed and run changes during CALC SHALL be ignored.
REQ-021 DONE: hold ready=1 and Product while run=1; on the first edge with run=0, go to IDLE and clear ready.
REQ-022 Product SHALL keep the last result in IDLE and CALC until the next completion or reset.
REQ-023 busy SHALL be 1 exactly in CALC; ready exactly in DONE.
REQ-024 Signed corner case: (-2^(WIDTH-1)) x (-2^(WIDTH-1)) SHALL give +2^(2*WIDTH-2) with no overflow.
REQ-025 Zero operands SHALL still take the full WIDTH iterations; there is no early termination.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, Product=0, ready=0, busy=0, and clear the accumulator, counter and q_-1, independent of clk.
REQ-027 reset asserted mid-CALC or in DONE SHALL abort the operation with no partial result visible.
REQ-028 After reset deasserts, run must be sampled afresh in IDLE.
REQ-029 If reset and run are both high at an edge, reset wins.

Structure
REQ-030 Shared package mult_pkg: state enum (IDLE, CALC, DONE) and the constant DEFAULT_WIDTH=32.
REQ-031 One combinational sub-module mult_step (parametrised by WIDTH): takes accumulator, multiplicand, q_-1 and mode, returns the next accumulator and q_-1; the top holds the FSM, counter and registers.
REQ-032 Implementation target: 120-400 RTL lines; no multiplier operator inferred.

Verification
REQ-033 WIDTH=32, unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> Product=0xFFFFFFFE00000001, ready rises exactly 32 edges after acceptance.
REQ-034 WIDTH=32, signed, 0x80000000 x 0x80000000 -> 0x4000000000000000; signed 0xFFFFFFFD x 0x00000005 -> 0xFFFFFFFFFFFFFFF1.
REQ-035 WIDTH=8, 0xFF x 0x02: signed -> 0xFFFE; unsigned -> 0x01FE.
REQ-036 Reset pulse at iteration 10 of a 32-bit multiply -> Product=0, ready=0, busy=0 immediately; the next run completes correctly.
REQ-037 Hold run high 5 cycles after ready -> ready and Product stable; run low -> IDLE next edge and ready=0; operand toggling during CALC does not change the result.
REQ-038 Back-to-back stream of at least 1000 random operand pairs in both modes -> every Product matches the reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared state encoding and default operand width for the sequential multiplier.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mult_step.sv
// One multiply iteration, purely combinational: shift-add when unsigned, radix-2 Booth when signed.
// acc is {guard, high, low}: the guard holds the carry (unsigned) or the sign extension (Booth).
module mult_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] mcand,
   input  logic             q_m1,
   input  logic             is_signed,
   output logic [2*WIDTH:0] acc_next,
   output logic             q_m1_next
);
   logic [WIDTH:0]   high;
   logic [WIDTH-1:0] low;
   logic [WIDTH:0]   mcand_ext;
   logic [WIDTH:0]   sum;

   assign high      = acc[2*WIDTH:WIDTH];
   assign low       = acc[WIDTH-1:0];
   assign mcand_ext = is_signed ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};

   always_comb begin
      sum = high;
      if (is_signed) begin
         unique case ({low[0], q_m1})
            2'b01:   sum = high + mcand_ext;
            2'b10:   sum = high - mcand_ext;
            default: sum = high;
         endcase
      end else if (low[0]) begin
         sum = high + mcand_ext;
      end
   end

   // Unsigned: the guard is always zero going in, so sum[WIDTH] is the carry and a logical shift suffices.
   assign acc_next  = {is_signed & sum[WIDTH], sum, low[WIDTH-1:1]};
   assign q_m1_next = is_signed & low[0];
endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH multiplier, one step per clock; result appears WIDTH edges after run is accepted.
// No backpressure: the result is held in DONE until run drops, and run is only sampled in IDLE.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   Multiplicand,
   input  logic [WIDTH-1:0]   Multiplier,
   output logic [2*WIDTH-1:0] Product,
   output logic               ready,
   output logic               busy
);
   state_t           state;
   state_t           state_next;
   logic [2*WIDTH:0] acc;
   logic [2*WIDTH:0] acc_step;
   logic [WIDTH-1:0] mcand;
   logic             mode;
   logic             q_m1;
   logic             q_m1_step;
   logic [CNT_W-1:0] cnt;
   logic             last_iter;

   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc       (acc),
      .mcand     (mcand),
      .q_m1      (q_m1),
      .is_signed (mode),
      .acc_next  (acc_step),
      .q_m1_next (q_m1_step)
   );

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      ready      = 1'b0;
      unique case (state)
         IDLE: begin
            if (run) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            ready = 1'b1;
            if (!run) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The multiplier sits in the low half and is consumed one bit per step as the accumulator shifts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         mcand   <= '0;
         mode    <= 1'b0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         Product <= '0;
      end else if (state == IDLE && run) begin
         acc   <= {{(WIDTH + 1){1'b0}}, Multiplier};
         mcand <= Multiplicand;
         mode  <= is_signed;
         q_m1  <= 1'b0;
         cnt   <= '0;
      end else if (state == CALC) begin
         acc  <= acc_step;
         q_m1 <= q_m1_step;
         cnt  <= cnt + CNT_W'(1);
         if (last_iter) Product <= acc_step[2*WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_multiplier;
   localparam int W  = 32;
   localparam int W8 = 8;

   typedef struct {
      logic [127:0] prod;
      int           acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset32 = 1'b0, run32 = 1'b0, sgn32 = 1'b0, rdy32, bsy32;
   logic [W-1:0]  mc32 = '0, mp32 = '0;
   logic [2*W-1:0] prod32;
   logic          reset8 = 1'b0, run8 = 1'b0, sgn8 = 1'b0, rdy8, bsy8;
   logic [W8-1:0] mc8 = '0, mp8 = '0;
   logic [2*W8-1:0] prod8;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [63:0] last32 = '0;
   exp_t q32[$];
   exp_t q8[$];

   seq_multiplier #(.WIDTH(W)) dut32 (
      .clk(clk), .reset(reset32), .run(run32), .is_signed(sgn32),
      .Multiplicand(mc32), .Multiplier(mp32), .Product(prod32), .ready(rdy32), .busy(bsy32)
   );

   seq_multiplier #(.WIDTH(W8)) dut8 (
      .clk(clk), .reset(reset8), .run(run8), .is_signed(sgn8),
      .Multiplicand(mc8), .Multiplier(mp8), .Product(prod8), .ready(rdy8), .busy(bsy8)
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input bit s);
      if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
      return 64'(a) * 64'(b);
   endfunction

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit s);
      if (s) return 16'(int'($signed(a)) * int'($signed(b)));
      return 16'(a) * 16'(b);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: pop an expectation on each rising ready and check value plus exact latency.
   logic r32_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rdy32 && !r32_prev) begin
         if (q32.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected32: ready rose with nothing pending");
         end else begin
            e = q32.pop_front();
            check("product32", prod32, e.prod);
            check("latency32", cyc, e.acc_cyc + W);
         end
      end
      r32_prev = rdy32;
   end

   logic r8_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rdy8 && !r8_prev) begin
         if (q8.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected8: ready rose with nothing pending");
         end else begin
            e = q8.pop_front();
            check("product8", prod8, e.prod);
            check("latency8", cyc, e.acc_cyc + W8);
         end
      end
      r8_prev = rdy8;
   end

   // hold > 0 keeps run high for that many cycles in DONE, checking the result stays put.
   task automatic mul32(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [63:0] ex, input int hold);
      exp_t e;
      int k;
      @(negedge clk);
      run32 = 1'b1; mc32 = a; mp32 = b; sgn32 = s;
      e.prod = 128'(ex); e.acc_cyc = cyc + 1;
      q32.push_back(e);
      @(negedge clk);
      if (hold == 0) run32 = 1'b0;
      mc32 = $urandom; mp32 = $urandom; sgn32 = ~s;
      check("busy_calc32", bsy32, 1'b1);
      check("prod_kept_calc32", prod32, last32);
      k = 0;
      while (!rdy32 && k < W + 4) begin
         @(negedge clk);
         k++;
      end
      if (!rdy32) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout32: ready=%0b after %0d cycles, expected 1", rdy32, k);
      end
      last32 = ex;
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready32", rdy32, 1'b1);
            check("hold_prod32", prod32, ex);
         end
         run32 = 1'b0;
         @(negedge clk);
         check("idle_ready32", rdy32, 1'b0);
         check("idle_busy32", bsy32, 1'b0);
         check("idle_prod32", prod32, ex);
      end
   endtask

   task automatic mul8(input logic [7:0] a, input logic [7:0] b, input bit s, input logic [15:0] ex);
      exp_t e;
      int k;
      @(negedge clk);
      run8 = 1'b1; mc8 = a; mp8 = b; sgn8 = s;
      e.prod = 128'(ex); e.acc_cyc = cyc + 1;
      q8.push_back(e);
      @(negedge clk);
      run8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom); sgn8 = ~s;
      check("busy_calc8", bsy8, 1'b1);
      k = 0;
      while (!rdy8 && k < W8 + 4) begin
         @(negedge clk);
         k++;
      end
      if (!rdy8) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout8: ready=%0b after %0d cycles, expected 1", rdy8, k);
      end
   endtask

   initial begin
      #1;
      reset32 = 1'b1;
      reset8  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_prod32", prod32, 64'h0);
      check("rst_ready32", rdy32, 1'b0);
      check("rst_busy32", bsy32, 1'b0);
      check("rst_prod8", prod8, 16'h0);
      check("rst_ready8", rdy8, 1'b0);
      reset32 = 1'b0;
      reset8  = 1'b0;

      fork
         begin
            mul32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0);
            mul32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0);
            mul32(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, 5);
            mul32(32'h00000000, 32'h00000000, 1'b1, 64'h0, 0);

            // Abort mid-CALC: nothing from the aborted multiply may leak out.
            @(negedge clk);
            run32 = 1'b1; mc32 = 32'hDEADBEEF; mp32 = 32'h12345678; sgn32 = 1'b0;
            @(negedge clk);
            run32 = 1'b0;
            repeat (9) @(negedge clk);
            reset32 = 1'b1;
            #1;
            check("abort_prod32", prod32, 64'h0);
            check("abort_ready32", rdy32, 1'b0);
            check("abort_busy32", bsy32, 1'b0);
            run32 = 1'b1;
            @(negedge clk);
            check("reset_wins_busy32", bsy32, 1'b0);
            run32 = 1'b0;
            reset32 = 1'b0;
            last32 = '0;
            mul32(32'h0000FFFF, 32'h00010001, 1'b0, 64'h00000000FFFFFFFF, 0);

            for (int i = 0; i < 1000; i++) begin
               logic [31:0] a, b;
               bit s;
               a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
               mul32(a, b, s, ref32(a, b, s), 0);
            end
         end
         begin
            mul8(8'hFF, 8'h02, 1'b1, 16'hFFFE);
            mul8(8'hFF, 8'h02, 1'b0, 16'h01FE);
            mul8(8'h80, 8'h80, 1'b1, 16'h4000);
            mul8(8'h7F, 8'h80, 1'b1, 16'hC080);
            for (int i = 0; i < 400; i++) begin
               logic [7:0] a, b;
               bit s;
               a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
               mul8(a, b, s, ref8(a, b, s));
            end
         end
      join

      repeat (5) @(negedge clk);
      check("drain32", q32.size(), 0);
      check("drain8", q8.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end
endmodule
